// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall bit values, FSM
// states, multi-cycle op classes and the canonical stall patterns.
package pipe_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // state   | meaning
   // S_RUN   | normal flow, waiting for a multi-cycle op or a flush
   // S_MULTI | EX busy with madd/msub or div, counter running
   // S_FLUSH | one-cycle flush pulse with redirect PC on new_pc
   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_MULTI = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam logic [1:0] MC_NONE = 2'b00;
   localparam logic [1:0] MC_MADD = 2'b01;
   localparam logic [1:0] MC_DIV  = 2'b10;

   // bit5..bit0 = WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC
   localparam logic [5:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
   localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
   localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
   localparam logic [5:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

   // Only madd-class and div-class ops start a sequence; 00 and 11 are ignored.
   function automatic logic is_mc_op(input logic [1:0] op);
      return (op == MC_MADD) || (op == MC_DIV);
   endfunction

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Multi-cycle op counter: latches the op length, steps the cycle index and
// flags the final cycle. It never wraps because it stops at len-1.
module mc_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_len,
   input  logic             active,
   input  logic             abort,
   input  logic             hold,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done
);

   logic [CNT_W-1:0] len;
   logic [CNT_W-1:0] len_m1;

   assign len_m1 = len - CNT_W'(1);
   assign busy   = active && (cnt < len_m1);
   assign done   = active && (cnt == len_m1);

   // Abort beats load so a flush in the start cycle never begins an op;
   // at the final index the count holds while MEM stalls, else returns to 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len <= '0;
         cnt <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (load) begin
         len <= load_len;
         cnt <= CNT_W'(1);
      end else if (busy) begin
         cnt <= cnt + CNT_W'(1);
      end else if (done && !hold) begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences EX multi-cycle ops
// and issues registered one-cycle flushes with a redirect PC.
//
// state   | meaning
// S_RUN   | normal flow, waiting for a multi-cycle op or a flush
// S_MULTI | EX busy with a multi-cycle op, counter running
// S_FLUSH | flush=1 for one cycle, new_pc holds the handler address
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MADD_CYCLES = 2,
   parameter int DIV_CYCLES  = 34,
   parameter int CNT_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_mem,
   input  logic             mc_start,
   input  logic [1:0]       mc_op,
   input  logic             flush_req,
   input  logic [31:0]      flush_pc,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic [CNT_W-1:0] mc_cnt,
   output logic             mc_done
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             mc_load;
   logic             mc_busy;
   logic             ex_busy;
   logic [CNT_W-1:0] len_sel;

   assign mc_load = (state == S_RUN) && mc_start && is_mc_op(mc_op) && !flush_req;
   assign len_sel = (mc_op == MC_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MADD_CYCLES);
   // The start cycle already stalls EX even though the FSM is still in RUN.
   assign ex_busy = mc_busy || mc_load;

   mc_counter #(.CNT_W(CNT_W)) u_mc_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (mc_load),
      .load_len (len_sel),
      .active   (state == S_MULTI),
      .abort    (flush_req),
      .hold     (stallreq_mem),
      .cnt      (mc_cnt),
      .busy     (mc_busy),
      .done     (mc_done)
   );

   // Next-state logic; a flush request wins from every state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN: begin
            if (flush_req)    state_nxt = S_FLUSH;
            else if (mc_load) state_nxt = S_MULTI;
         end
         S_MULTI: begin
            if (flush_req)                    state_nxt = S_FLUSH;
            else if (mc_done && !stallreq_mem) state_nxt = S_RUN;
         end
         S_FLUSH: begin
            state_nxt = flush_req ? S_FLUSH : S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
   end

   // State register plus registered flush pulse and redirect PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_RUN;
         flush  <= 1'b0;
         new_pc <= '0;
      end else begin
         state <= state_nxt;
         flush <= flush_req;
         if (flush_req) new_pc <= flush_pc;
      end
   end

   // Priority stall encoder; zero latency from the request inputs.
   always_comb begin
      stall = STALL_NONE;
      if (flush)             stall = STALL_NONE;
      else if (stallreq_mem) stall = STALL_MEM;
      else if (ex_busy)      stall = STALL_EX;
      else if (stallreq_id)  stall = STALL_ID;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector that freezes the PC and the inter-stage registers (if_id, id_ex, ex_mem, mem_wb). It sequences the EX-stage multi-cycle operations (madd/msub, div) with an internal cycle counter that it exposes to the EX stage. It also issues one-cycle pipeline flushes with a redirect PC for exceptions.

## Interface

Parameters:
- `MADD_CYCLES`, default 2: total EX cycles of madd/maddu/msub/msubu.
- `DIV_CYCLES`, default 34: total EX cycles of div/divu.
- `CNT_W`, default 6: counter width; must satisfy 2^CNT_W > DIV_CYCLES.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `stallreq_id` in 1: ID requests a stall (load-use hazard).
- `stallreq_mem` in 1: MEM requests a stall (memory wait).
- `mc_start` in 1: EX begins a multi-cycle op this cycle.
- `mc_op` in 2: op class, sampled with `mc_start`. 00 none, 01 madd class, 10 div class, 11 reserved (treated as none).
- `flush_req` in 1: exception detected; flush the pipeline.
- `flush_pc` in 32: handler address, sampled with `flush_req`.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB. 1 = Stop.
- `flush` out 1: registered one-cycle flush pulse.
- `new_pc` out 32: registered redirect PC; valid while `flush`=1.
- `mc_cnt` out CNT_W: current cycle index of the multi-cycle op, going to EX.
- `mc_done` out 1: final cycle of the multi-cycle op; EX result is valid.

## Operation

FSM states: RUN, MULTI, FLUSH.

Stall vector (combinational). Apply the first matching rule:
- `flush`=1 → 000000.
- `stallreq_mem` → 011111.
- EX busy (state MULTI, `mc_cnt` < LEN−1) → 001111.
- `stallreq_id` → 000111.
- Otherwise → 000000.

RUN:
- `flush_req` → go to FLUSH. This takes priority over everything, including `mc_start`.
- `mc_start` with op 01/10 → go to MULTI with LEN = MADD_CYCLES or DIV_CYCLES, latched in a register. `mc_cnt` becomes 1 on the next edge. In the start cycle itself `mc_cnt`=0 and `stall`=001111.
- `mc_start` with op 00/11 → ignored.

MULTI:
- `mc_cnt` increments each cycle while below LEN−1.
- When `mc_cnt` = LEN−1:
  - `mc_done`=1 and the EX stall request drops, so EX/MEM captures the result that cycle.
  - If `stallreq_mem`=0, return to RUN with `mc_cnt` set to 0.
  - If `stallreq_mem`=1, hold at LEN−1 with `mc_done` held until the MEM stall clears.
- `flush_req` aborts the op: `mc_cnt` set to 0, go to FLUSH.
- `mc_start` is ignored in MULTI.

FLUSH:
- Lasts one cycle; `flush`=1 and `new_pc` holds the sampled `flush_pc`.
- Next state is RUN, or FLUSH again if `flush_req` is asserted. A back-to-back flush captures the newer `flush_pc`.

Other rules:
- `mc_done` = (state MULTI) && (`mc_cnt` = LEN−1). It is never asserted otherwise.
- Counter arithmetic is unsigned CNT_W and never wraps, because it is bounded by LEN−1.

## Timing

- Reset values: state RUN, `flush`=0, `new_pc`=0, `mc_cnt`=0, LEN register 0, `mc_done`=0, `stall`=000000 (no requests asserted).
- `flush_req` in cycle N → `flush`=1 and `new_pc` valid in cycle N+1, for exactly one cycle.
- `mc_start` in cycle N:
  - `mc_cnt` = k in cycle N+k.
  - `mc_done` in cycle N+LEN−1, so the op occupies EX for exactly LEN cycles when MEM does not stall.
- Reset asserted mid-operation → immediate return to reset values; the op is not resumed.
- `stall` has zero latency from its request inputs.

## Structure

- Shared package/define file holds: `Stop`/`NoStop`, the FSM state encodings, the `mc_op` encodings (MC_NONE, MC_MADD, MC_DIV), and the stall patterns STALL_ID=000111, STALL_EX=001111, STALL_MEM=011111.
- Natural sub-module: `mc_counter`, containing the LEN register, the counter and the `mc_done` compare. The FSM and stall encoder stay in the top level.

## Test plan

- Reset with all inputs 0 → all outputs 0. Then pulse `stallreq_id` → `stall`=000111 in the same cycle; the request drops → `stall`=000000.
- `mc_start`, `mc_op`=01 at cycle N → `mc_cnt` 0,1 at cycles N, N+1. `mc_done`=1 at N+1. `stall`=001111 at N only. RUN at N+2.
- `mc_start`, `mc_op`=10 at N → `stall`=001111 for cycles N..N+32, `mc_done` at N+33, `mc_cnt` reaches 33, then returns to 0.
- Div running at `mc_cnt`=10 and `flush_req` with `flush_pc`=0x0000_0120 → next cycle `flush`=1, `new_pc`=0x120, `mc_cnt`=0, `stall`=0. The cycle after that, `flush`=0.
- Madd final cycle with `stallreq_mem`=1 for 3 cycles → `mc_done` held for 4 cycles, `stall`=011111 for 3 cycles, then RUN.
- `flush_req` and `mc_start` in the same cycle → FLUSH wins and no multi-cycle op starts. `flush_req` on two consecutive cycles (0x100, 0x200) → `flush`=1 for two cycles with `new_pc` 0x100 then 0x200.
